// File: rtl/cmd_uart_rx_pkg.sv
// Shared types and constants for the serial command receiver.
package cmd_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned CLKS_PER_BIT_DEF = 2604;
  localparam int unsigned BAUD_CNT_W       = 12;

endpackage

// File: rtl/cmd_uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the value both flops take in reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cmd_uart_rx.sv
// 8N1 UART command receiver with a level cmd_rdy / clr_cmd_rdy handshake.
// Define CMD_RX_FRAME_CHK_EN to reject frames whose stop bit is low.
module cmd_uart_rx
  import cmd_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_cmd_rdy,
  output logic [7:0] cmd,
  output logic       cmd_rdy,
  output logic       overrun,
  output logic       frm_err
);

  localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic                  rx_s;
  logic                  stop_ok;
  rx_state_t             state_q;
  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shift_q;
  logic [7:0]            cmd_q;
  logic                  rdy_q;
  logic                  ovr_q;

  sync2 #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (RX),
    .q_o (rx_s)
  );

`ifdef CMD_RX_FRAME_CHK_EN
  logic ferr_q;
  assign stop_ok = rx_s;
`else
  assign stop_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cmd_q     <= '0;
      rdy_q     <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef CMD_RX_FRAME_CHK_EN
      ferr_q    <= 1'b0;
`endif
    end else begin
      ovr_q <= 1'b0;
`ifdef CMD_RX_FRAME_CHK_EN
      ferr_q <= 1'b0;
`endif
      // Acceptance in STOP below overrides this clear (set wins over clear).
      if (clr_cmd_rdy) rdy_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (stop_ok) begin
              cmd_q <= shift_q;
              rdy_q <= 1'b1;
              ovr_q <= rdy_q & ~clr_cmd_rdy;
            end
`ifdef CMD_RX_FRAME_CHK_EN
            else begin
              ferr_q <= 1'b1;
            end
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;
  assign overrun = ovr_q;
`ifdef CMD_RX_FRAME_CHK_EN
  assign frm_err = ferr_q;
`else
  assign frm_err = 1'b0;
`endif

endmodule
